// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-stage program counter. It holds the fetch address PCF and picks the
//   next PC from one of four sources: sequential (+2 or +4), the predicted
//   target, the Execute-stage correction, or the predicted return taken from
//   a circular return-address stack (RAS).
//
//   Optional feature macro: RAS_EN. When it is defined, the RAS is built.
//   When it is undefined, no RAS is built, CallF is ignored, PCSrc=11 acts
//   like sequential, RASEmpty is tied to 1 and RASTop is tied to 0.
//
// Parameters
//   XLEN          address width (>= 16)
//   RESET_VECTOR  value of PCF after reset (2-byte aligned)
//   RAS_DEPTH     number of RAS entries (power of two, >= 2)
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   StallF       holds PCF and the RAS
//   PCSrc        00 seq, 01 target, 10 mispredict correction, 11 return
//   TargetAddr   predicted branch/jump target
//   PCNextE      corrected PC from Execute
//   InstrCompF   instruction at PCF is 16-bit
//   CallF        instruction at PCF is a call (push its return address)
//   PCF          current fetch address
//   PCNextF      sequential next PC (combinational)
//   RASTop       RAS top entry, 0 when the RAS is empty
//   RASEmpty     RAS holds no valid entries
module fetch_pc_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] TargetAddr,
  input  logic [XLEN-1:0] PCNextE,
  input  logic            InstrCompF,
  input  logic            CallF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCNextF,
  output logic [XLEN-1:0] RASTop,
  output logic            RASEmpty
);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pc_next_f;
  logic [XLEN-1:0] pc_sel;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  // The sum is truncated to XLEN bits, so the PC wraps modulo 2^XLEN.
  assign pc_next_f = pcf_q + (InstrCompF ? XLEN'(2) : XLEN'(4));

  // A return with an empty RAS falls back to sequential fetch. With the
  // RAS left out, ras_empty is constant 1, so PCSrc=11 acts as 00.
  always_comb begin
    pc_sel = pc_next_f;
    case (PCSrc)
      2'b01:   pc_sel = TargetAddr;
      2'b10:   pc_sel = PCNextE;
      2'b11:   pc_sel = ras_empty ? pc_next_f : ras_top;
      default: pc_sel = pc_next_f;
    endcase
    pcf_d = StallF ? pcf_q : pc_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pcf_q <= RESET_VECTOR;
    else       pcf_q <= pcf_d;
  end

`ifdef RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [RAS_DEPTH-1:0][XLEN-1:0] ras_q, ras_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           push, pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : ras_q[ptr_q];

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    push  = CallF && (PCSrc != 2'b10);
    pop   = (PCSrc == 2'b11) && !ras_empty;
    if (!StallF) begin
      if (PCSrc == 2'b10) begin
        // A mispredict flushes the stack. The entries stay, but they are invalid.
        cnt_d = '0;
      end else if (push && pop) begin
        // A call that is also a return swaps the top entry in place.
        ras_d[ptr_q] = pc_next_f;
      end else if (push) begin
        // When full, the pointer wraps onto the oldest entry and overwrites it.
        ptr_d        = ptr_q + 1'b1;
        ras_d[ptr_d] = pc_next_f;
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
      end else if (pop) begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage has no reset. The count alone marks which entries are valid.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
`else
  logic unused_call;
  logic unused_depth;

  assign ras_empty    = 1'b1;
  assign ras_top      = '0;
  assign unused_call  = CallF;
  assign unused_depth = (RAS_DEPTH == 0);
`endif

  assign PCF      = pcf_q;
  assign PCNextF  = pc_next_f;
  assign RASTop   = ras_top;
  assign RASEmpty = ras_empty;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h100;
`ifdef RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] TargetAddr = '0;
  logic [31:0] PCNextE = '0;
  logic        InstrCompF = 1'b0;
  logic        CallF = 1'b0;
  logic [31:0] PCF, PCNextF, RASTop;
  logic        RASEmpty;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrc(PCSrc),
    .TargetAddr(TargetAddr), .PCNextE(PCNextE), .InstrCompF(InstrCompF),
    .CallF(CallF), .PCF(PCF), .PCNextF(PCNextF), .RASTop(RASTop),
    .RASEmpty(RASEmpty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] nxe;
    logic        comp;
    logic        call;
    logic [31:0] exp_pcf;
    logic [31:0] exp_top;
    logic        exp_empty;
  } vec_t;

  vec_t vq[$];

  // pcf_r/top_r/emp_r: expected values with the RAS built; pcf_n: expected PCF without it.
  function automatic vec_t mk(logic rst, logic stall, logic [1:0] src,
                              logic [31:0] tgt, logic [31:0] nxe, logic comp,
                              logic call, logic [31:0] pcf_r, logic [31:0] top_r,
                              logic emp_r, logic [31:0] pcf_n);
    vec_t v;
    v.rst = rst; v.stall = stall; v.src = src; v.tgt = tgt; v.nxe = nxe;
    v.comp = comp; v.call = call;
    v.exp_pcf   = RAS_ON ? pcf_r : pcf_n;
    v.exp_top   = RAS_ON ? top_r : 32'h0;
    v.exp_empty = RAS_ON ? emp_r : 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] pcf,
                         input logic [31:0] top, input logic emp);
    chk("PCF", idx, PCF, pcf);
    chk("RASTop", idx, RASTop, top);
    chk("RASEmpty", idx, {31'b0, RASEmpty}, {31'b0, emp});
  endtask

  initial begin
    //              rst stl src   tgt           nxe          c  call pcf_r         top_r     e  pcf_n
    vq.push_back(mk(1, 0, 2'b00, 32'h0,        32'h0,       0, 0, 32'h100,      32'h0,   1, 32'h100));
    vq.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,       0, 0, 32'h104,      32'h0,   1, 32'h104));
    vq.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,       0, 0, 32'h108,      32'h0,   1, 32'h108));
    vq.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,       1, 0, 32'h10A,      32'h0,   1, 32'h10A));
    vq.push_back(mk(0, 0, 2'b01, 32'hFFFFFFFC, 32'h0,       0, 0, 32'hFFFFFFFC, 32'h0,   1, 32'hFFFFFFFC));
    vq.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,       0, 0, 32'h0,        32'h0,   1, 32'h0));
    vq.push_back(mk(0, 0, 2'b01, 32'h2000,     32'h0,       0, 0, 32'h2000,     32'h0,   1, 32'h2000));
    vq.push_back(mk(0, 0, 2'b01, 32'h40,       32'h0,       0, 0, 32'h40,       32'h0,   1, 32'h40));
    vq.push_back(mk(0, 0, 2'b01, 32'h800,      32'h0,       0, 1, 32'h800,      32'h44,  0, 32'h800));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 1, 2'b01, 32'h5000,   32'h0,       0, 1, 32'h800,      32'h44,  0, 32'h800));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h44,       32'h0,   1, 32'h804));
    vq.push_back(mk(0, 0, 2'b01, 32'h50,       32'h0,       0, 0, 32'h50,       32'h0,   1, 32'h50));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h54,       32'h0,   1, 32'h54));
    vq.push_back(mk(0, 0, 2'b01, 32'h1000,     32'h0,       0, 1, 32'h1000,     32'h58,  0, 32'h1000));
    vq.push_back(mk(0, 0, 2'b10, 32'h0,        32'h3000,    0, 1, 32'h3000,     32'h0,   1, 32'h3000));
    // Overflow: five pushes into a four-deep stack, then five pops.
    vq.push_back(mk(0, 0, 2'b01, 32'hC,        32'h0,       0, 0, 32'hC,        32'h0,   1, 32'hC));
    vq.push_back(mk(0, 0, 2'b01, 32'h1C,       32'h0,       0, 1, 32'h1C,       32'h10,  0, 32'h1C));
    vq.push_back(mk(0, 0, 2'b01, 32'h2C,       32'h0,       0, 1, 32'h2C,       32'h20,  0, 32'h2C));
    vq.push_back(mk(0, 0, 2'b01, 32'h3C,       32'h0,       0, 1, 32'h3C,       32'h30,  0, 32'h3C));
    vq.push_back(mk(0, 0, 2'b01, 32'h4C,       32'h0,       0, 1, 32'h4C,       32'h40,  0, 32'h4C));
    vq.push_back(mk(0, 0, 2'b01, 32'h600,      32'h0,       0, 1, 32'h600,      32'h50,  0, 32'h600));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h50,       32'h40,  0, 32'h604));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h40,       32'h30,  0, 32'h608));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h30,       32'h20,  0, 32'h60C));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h20,       32'h0,   1, 32'h610));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h24,       32'h0,   1, 32'h614));
    // Call and return in the same cycle: the top is replaced and the count is unchanged.
    vq.push_back(mk(0, 0, 2'b01, 32'h70,       32'h0,       0, 1, 32'h70,       32'h28,  0, 32'h70));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 1, 32'h28,       32'h74,  0, 32'h74));
    vq.push_back(mk(0, 0, 2'b11, 32'h0,        32'h0,       0, 0, 32'h74,       32'h0,   1, 32'h78));
    vq.push_back(mk(0, 0, 2'b01, 32'h900,      32'h0,       0, 1, 32'h900,      32'h78,  0, 32'h900));

    // Asynchronous reset with no clock edge; PCNextF follows from the reset PC.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_PCF", -1, PCF, RV);
    chk("async_rst_PCNextF", -1, PCNextF, 32'h104);
    chk("async_rst_RASTop", -1, RASTop, 32'h0);
    chk("async_rst_RASEmpty", -1, {31'b0, RASEmpty}, 32'h1);

    @(negedge clk);
    foreach (vq[i]) begin
      reset = vq[i].rst; StallF = vq[i].stall; PCSrc = vq[i].src;
      TargetAddr = vq[i].tgt; PCNextE = vq[i].nxe;
      InstrCompF = vq[i].comp; CallF = vq[i].call;
      @(posedge clk); #1;
      chk_all(i, vq[i].exp_pcf, vq[i].exp_top, vq[i].exp_empty);
      @(negedge clk);
    end

    // Reset in the middle of operation takes effect at once, not at the next edge.
    StallF = 1'b0; PCSrc = 2'b00; CallF = 1'b0; InstrCompF = 1'b0;
    reset = 1'b1;
    #1;
    chk_all(100, RV, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk_all(101, RV, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all(102, 32'h104, 32'h0, 1'b1);
    chk("PCNextF_seq", 102, PCNextF, 32'h108);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
